// File: rtl/ktu_pkg.sv
// Shared constants, FSM state type and element-indexing helper for the
// kernel-transform scheduler and its output serializer.
package ktu_pkg;

   localparam int KTU_DATA_W = 16;
   localparam int KSIZE      = 3;
   localparam int TSIZE      = 6;
   localparam int KELEMS     = KSIZE * KSIZE;
   localparam int TELEMS     = TSIZE * TSIZE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_KRST,
      ST_WAIT,
      ST_WRITE,
      ST_FIN
   } kts_state_e;

   // Row-major flat index of element (row, col) in a width-wide square matrix.
   function automatic int unsigned elem_idx(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned width);
      return row * width + col;
   endfunction

endpackage

// File: rtl/ktu_out_serializer.sv
// Captures the 36-word transformed kernel and presents it one element at a
// time on a valid/ready write port, row-major.
module ktu_out_serializer
   import ktu_pkg::*;
#(
   parameter int DATA_W = KTU_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [TELEMS*DATA_W-1:0] kernel_out,
   input  logic                     valid,
   input  logic                     ready,
   output logic [DATA_W-1:0]        data,
   output logic [5:0]               idx,
   output logic                     last_accept
);

   logic [DATA_W-1:0] words_q [TELEMS];
   logic [5:0]        idx_q;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         // NOTE: the capture array is reset so wr_data reads zero after reset, not stale data.
         for (int i = 0; i < TELEMS; i++) words_q[i] <= '0;
         idx_q <= '0;
      end else if (load) begin
         for (int r = 0; r < TSIZE; r++) begin
            for (int c = 0; c < TSIZE; c++) begin
               words_q[elem_idx(r, c, TSIZE)] <= kernel_out[elem_idx(r, c, TSIZE)*DATA_W +: DATA_W];
            end
         end
         idx_q <= '0;
      end else if (valid && ready) begin
         idx_q <= last_accept ? '0 : idx_q + 6'd1;
      end
   end

   assign data        = words_q[idx_q];
   assign idx         = idx_q;
   assign last_accept = valid && ready && (idx_q == 6'(TELEMS - 1));

endmodule

// File: rtl/kernel_transform_scheduler.sv
// Batch sequencer for the Winograd kernel transform unit: fetch 9 words,
// pulse the unit out of reset, wait for its result, stream 36 words out.
module kernel_transform_scheduler
   import ktu_pkg::*;
#(
   parameter int DATA_W      = KTU_DATA_W,
   parameter int KADDR_W     = 10,
   parameter int OADDR_W     = 12,
   parameter int CNT_W       = 5,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_kernels,
   input  logic [KADDR_W-1:0]       src_base,
   input  logic [OADDR_W-1:0]       dst_base,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic                     kmem_rd_en,
   output logic [KADDR_W-1:0]       kmem_rd_addr,
   input  logic [DATA_W-1:0]        kmem_rd_data,
   output logic                     ktu_rst_n,
   output logic [KELEMS*DATA_W-1:0] ktu_kernel_in,
   input  logic [TELEMS*DATA_W-1:0] ktu_kernel_out,
   input  logic                     ktu_transform_done,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [OADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]        wr_data
);

   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

   kts_state_e               state_q, state_d;
   logic [CNT_W-1:0]         num_q, k_q;
   logic [KADDR_W-1:0]       src_q;
   logic [OADDR_W-1:0]       dst_q;
   logic [3:0]               fe_q;
   logic                     rd_pend_q;
   logic [3:0]               slot_q;
   logic [TCNT_W-1:0]        tcnt_q;
   logic                     error_q;
   logic [KELEMS*DATA_W-1:0] kin_q;

   logic [5:0] wr_idx;
   logic       last_accept;
   logic       cap_load;
   logic       timeout_hit;
   logic       last_kernel;

   assign cap_load    = (state_q == ST_WAIT) && ktu_transform_done;
   assign timeout_hit = (state_q == ST_WAIT) && !ktu_transform_done &&
                        (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));
   assign last_kernel = (k_q + CNT_W'(1)) == num_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (num_kernels == '0) ? ST_FIN : ST_FETCH;
         ST_FETCH: if (fe_q == 4'(KELEMS)) state_d = ST_KRST;
         ST_KRST:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (cap_load)         state_d = ST_WRITE;
            else if (timeout_hit) state_d = ST_FIN;
         end
         ST_WRITE: if (last_accept) state_d = last_kernel ? ST_FIN : ST_FETCH;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         num_q     <= '0;
         k_q       <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         fe_q      <= '0;
         rd_pend_q <= 1'b0;
         slot_q    <= '0;
         tcnt_q    <= '0;
         error_q   <= 1'b0;
         kin_q     <= '0;
      end else begin
         // Read data lags the strobe by one cycle, so remember which slot it fills.
         rd_pend_q <= kmem_rd_en;
         slot_q    <= fe_q;
         if (rd_pend_q) kin_q[int'(slot_q)*DATA_W +: DATA_W] <= kmem_rd_data;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  num_q   <= num_kernels;
                  src_q   <= src_base;
                  dst_q   <= dst_base;
                  error_q <= 1'b0;
                  k_q     <= '0;
                  fe_q    <= '0;
               end
            end
            ST_FETCH: fe_q <= fe_q + 4'd1;
            ST_KRST:  tcnt_q <= '0;
            ST_WAIT: begin
               tcnt_q <= tcnt_q + TCNT_W'(1);
               if (timeout_hit) error_q <= 1'b1;
            end
            ST_WRITE: begin
               if (last_accept && !last_kernel) begin
                  k_q  <= k_q + CNT_W'(1);
                  fe_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   ktu_out_serializer #(
      .DATA_W(DATA_W)
   ) u_serializer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (cap_load),
      .kernel_out (ktu_kernel_out),
      .valid      (wr_valid),
      .ready      (wr_ready),
      .data       (wr_data),
      .idx        (wr_idx),
      .last_accept(last_accept)
   );

   assign busy          = (state_q == ST_FETCH) || (state_q == ST_KRST) ||
                          (state_q == ST_WAIT)  || (state_q == ST_WRITE);
   assign done          = (state_q == ST_FIN);
   assign error         = error_q;
   assign kmem_rd_en    = (state_q == ST_FETCH) && (fe_q < 4'(KELEMS));
   assign kmem_rd_addr  = src_q + KADDR_W'(KELEMS) * KADDR_W'(k_q) + KADDR_W'(fe_q);
   assign ktu_rst_n     = (state_q == ST_WAIT);
   assign ktu_kernel_in = kin_q;
   assign wr_valid      = (state_q == ST_WRITE);
   assign wr_addr       = dst_q + OADDR_W'(TELEMS) * OADDR_W'(k_q) + OADDR_W'(wr_idx);

endmodule

// File: tb/tb_kernel_transform_scheduler.sv
// Scoreboard bench: expected reads/kernels/writes are queued per batch and a
// negedge monitor checks every DUT transaction against the queue heads.
module tb_kernel_transform_scheduler;
   import ktu_pkg::*;

   localparam int DW = 16;
   localparam int KA = 10;
   localparam int OA = 12;
   localparam int CW = 5;
   localparam int TO = 64;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic [CW-1:0]        num_kernels;
   logic [KA-1:0]        src_base;
   logic [OA-1:0]        dst_base;
   logic                 busy, done, error;
   logic                 kmem_rd_en;
   logic [KA-1:0]        kmem_rd_addr;
   logic [DW-1:0]        kmem_rd_data = '0;
   logic                 ktu_rst_n;
   logic [KELEMS*DW-1:0] ktu_kernel_in;
   logic [TELEMS*DW-1:0] ktu_kernel_out;
   logic                 ktu_transform_done = 1'b0;
   logic                 wr_valid;
   logic                 wr_ready = 1'b1;
   logic [OA-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;

   always #5 clk = ~clk;

   kernel_transform_scheduler #(
      .DATA_W(DW), .KADDR_W(KA), .OADDR_W(OA), .CNT_W(CW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_kernels(num_kernels),
      .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done), .error(error),
      .kmem_rd_en(kmem_rd_en), .kmem_rd_addr(kmem_rd_addr), .kmem_rd_data(kmem_rd_data),
      .ktu_rst_n(ktu_rst_n), .ktu_kernel_in(ktu_kernel_in), .ktu_kernel_out(ktu_kernel_out),
      .ktu_transform_done(ktu_transform_done), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Kernel memory model: mem[a] = a+1, read data one cycle after the strobe.
   logic [DW-1:0] mem [1 << KA];
   initial for (int a = 0; a < (1 << KA); a++) mem[a] = DW'(a + 1);
   always @(posedge clk) if (kmem_rd_en) kmem_rd_data <= mem[kmem_rd_addr];

   // KTU stub: out[n] = in[n % 9] + n, done 4 cycles after release unless hung.
   logic       ktu_hang = 1'b0;
   logic [2:0] kcnt = '0;
   always @(posedge clk) begin
      if (!ktu_rst_n) begin
         kcnt               <= '0;
         ktu_transform_done <= 1'b0;
      end else begin
         if (kcnt != 3'd4) kcnt <= kcnt + 3'd1;
         ktu_transform_done <= ktu_transform_done | (!ktu_hang && kcnt == 3'd3);
      end
   end
   always_comb begin
      ktu_kernel_out = '0;
      for (int n = 0; n < TELEMS; n++)
         ktu_kernel_out[n*DW +: DW] = ktu_kernel_in[(n % KELEMS)*DW +: DW] + DW'(n);
   end

   // Ready pattern 1,0,0,1 repeating when stalling is enabled.
   logic stall_mode = 1'b0;
   always @(posedge clk) wr_ready <= !stall_mode || (cyc % 4 == 0) || (cyc % 4 == 3);

   typedef struct packed {
      logic [OA-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic [KA-1:0]        exp_rd  [$];
   logic [KELEMS*DW-1:0] exp_kin [$];
   wr_t                  exp_wr  [$];

   task automatic check(input string name, input logic [KELEMS*DW-1:0] act,
                        input logic [KELEMS*DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag_extra(input string name, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got transaction %0h, expected none (cycle %0d)", name, act, cyc);
   endtask

   task automatic push_kernel(input int src, input int dst, input int k, input bit with_writes);
      logic [KELEMS*DW-1:0] kin;
      int a;
      kin = '0;
      for (int e = 0; e < KELEMS; e++) begin
         a = (src + KELEMS*k + e) % (1 << KA);
         exp_rd.push_back(KA'(a));
         kin[e*DW +: DW] = mem[a];
      end
      exp_kin.push_back(kin);
      if (with_writes)
         for (int n = 0; n < TELEMS; n++)
            exp_wr.push_back('{addr: OA'((dst + TELEMS*k + n) % (1 << OA)),
                               data: kin[(n % KELEMS)*DW +: DW] + DW'(n)});
   endtask

   // Monitor: every strobe/valid cycle is compared against the queue head.
   int   last_rd_cyc = 0;
   int   rise_cyc    = 0;
   int   done_cnt    = 0;
   int   done_cyc    = 0;
   logic prev_krst   = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_krst <= 1'b0;
      end else begin
         if (kmem_rd_en) begin
            last_rd_cyc <= cyc;
            if (exp_rd.size() == 0) flag_extra("rd_extra", 32'(kmem_rd_addr));
            else check("rd_addr", kmem_rd_addr, exp_rd.pop_front());
         end
         if (ktu_rst_n && !prev_krst) begin
            rise_cyc <= cyc;
            check("krst_gap", cyc - last_rd_cyc, 3);
            if (exp_kin.size() == 0) flag_extra("kin_extra", 32'(cyc));
            else check("kernel_in", ktu_kernel_in, exp_kin.pop_front());
         end
         prev_krst <= ktu_rst_n;
         if (wr_valid) begin
            if (exp_wr.size() == 0) flag_extra("wr_extra", 32'(wr_addr));
            else begin
               check("wr_addr", wr_addr, exp_wr[0].addr);
               check("wr_data", wr_data, exp_wr[0].data);
               if (wr_ready) void'(exp_wr.pop_front());
            end
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   // Returns the cycle number during which start is sampled-to-be.
   task automatic pulse_start(input int num, input int src, input int dst, output int issue_cyc);
      @(posedge clk); #1;
      issue_cyc   = cyc;
      start       = 1'b1;
      num_kernels = CW'(num);
      src_base    = KA'(src);
      dst_base    = OA'(dst);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         if (done_cnt != base) seen = 1'b1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, budget);
      end
   endtask

   task automatic end_of_batch(input int base, input logic exp_err, input string name);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({name, "_done_count"}, done_cnt - base, 1);
      check({name, "_error"}, error, exp_err);
      check({name, "_busy"}, busy, 0);
      check({name, "_rd_left"}, exp_rd.size(), 0);
      check({name, "_wr_left"}, exp_wr.size(), 0);
   endtask

   task automatic run_batch(input int num, input int src, input int dst,
                            input bit poke, input string name);
      int base, ic, dummy;
      base = done_cnt;
      for (int k = 0; k < num; k++) push_kernel(src, dst, k, 1'b1);
      pulse_start(num, src, dst, ic);
      @(negedge clk);
      check({name, "_busy_after_start"}, busy, 1);
      check({name, "_error_cleared"}, error, 0);
      if (poke) begin
         repeat (20) @(posedge clk);
         pulse_start(5, 900, 3000, dummy);
      end
      wait_done(base, 2000, name);
      end_of_batch(base, 1'b0, name);
   endtask

   initial begin
      int base, ic;
      rst_n = 1'b0; start = 1'b0;
      num_kernels = '0; src_base = '0; dst_base = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_rd_en", kmem_rd_en, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_ktu_rst_n", ktu_rst_n, 0);
      check("rst_rd_addr", kmem_rd_addr, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_kernel_in", ktu_kernel_in, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_batch(1, 0, 40, 1'b0, "single");
      run_batch(3, 100, 200, 1'b1, "batch3");
      run_batch(1, 1020, 4090, 1'b0, "wrap");
      stall_mode = 1'b1;
      run_batch(2, 50, 1000, 1'b0, "stall");
      stall_mode = 1'b0;

      // KTU never finishes: timeout after TO cycles in WAIT, error sticky.
      ktu_hang = 1'b1;
      base = done_cnt;
      push_kernel(300, 0, 0, 1'b0);
      pulse_start(2, 300, 0, ic);
      wait_done(base, 500, "timeout");
      end_of_batch(base, 1'b1, "timeout");
      check("timeout_latency", done_cyc - rise_cyc, TO);
      ktu_hang = 1'b0;
      run_batch(1, 10, 20, 1'b0, "after_timeout");

      // Empty batch: done the cycle after start, no memory traffic.
      base = done_cnt;
      pulse_start(0, 7, 7, ic);
      wait_done(base, 20, "empty");
      end_of_batch(base, 1'b0, "empty");
      check("empty_latency", done_cyc - ic, 1);

      // Reset in the middle of kernel 2's write phase aborts silently.
      base = done_cnt;
      for (int k = 0; k < 3; k++) push_kernel(0, 0, k, 1'b1);
      pulse_start(3, 0, 0, ic);
      for (int i = 0; i < 1000 && exp_wr.size() > 2*TELEMS - 5; i++) @(posedge clk);
      check("abort_reached_k2", exp_wr.size() <= 2*TELEMS - 5, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_wr_valid", wr_valid, 0);
      check("abort_rd_en", kmem_rd_en, 0);
      check("abort_ktu_rst_n", ktu_rst_n, 0);
      check("abort_wr_addr", wr_addr, 0);
      check("abort_wr_data", wr_data, 0);
      check("abort_kernel_in", ktu_kernel_in, 0);
      exp_rd.delete();
      exp_kin.delete();
      exp_wr.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("abort_no_done", done_cnt - base, 0);
      check("abort_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
